// File: rtl/shifter_pkg.sv
// Shared types for the iterative multi-mode shifter.
//   shift_mode_t  : operation select, encoding matches the external 2-bit mode port
//   shift_state_t : controller states of shifter_seq
package shifter_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_mode_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } shift_state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift step.
// Ports:
//   i_data [M-1:0] : word to shift
//   i_mode         : LSL / LSR / ASR / ROR
//   o_data [M-1:0] : word after one bit position
//   o_bit          : bit ejected by this step
module shift_step
    import shifter_pkg::*;
#(
    parameter int unsigned M = 4
) (
    input  logic [M-1:0] i_data,
    input  shift_mode_t  i_mode,
    output logic [M-1:0] o_data,
    output logic         o_bit
);

    always_comb begin
        o_data = i_data;
        o_bit  = 1'b0;
        unique case (i_mode)
            SH_LSL: begin
                o_data = {i_data[M-2:0], 1'b0};
                o_bit  = i_data[M-1];
            end
            SH_LSR: begin
                o_data = {1'b0, i_data[M-1:1]};
                o_bit  = i_data[0];
            end
            SH_ASR: begin
                o_data = {i_data[M-1], i_data[M-1:1]};
                o_bit  = i_data[0];
            end
            SH_ROR: begin
                o_data = {i_data[0], i_data[M-1:1]};
                o_bit  = i_data[0];
            end
            default: begin
                o_data = i_data;
                o_bit  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shifter_seq.sv
// Iterative multi-mode shifter: one bit position per clock, start/done handshake,
// registered result with C/N/V/Z flags.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : request, sampled only in IDLE
//   A, B [M-1:0]  : shiftee, unsigned shift amount
//   mode [1:0]    : 00 LSL, 01 LSR, 10 ASR, 11 ROR
//   R [M-1:0]     : result (held until the next operation completes)
//   C, N, V, Z    : carry-out, sign, amount-out-of-range, zero
//   busy          : high in SHIFT and DONE
//   done          : one-cycle pulse when R and flags are valid
module shifter_seq
    import shifter_pkg::*;
#(
    parameter int unsigned M = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] A,
    input  logic [M-1:0] B,
    input  logic [1:0]   mode,
    output logic [M-1:0] R,
    output logic         C,
    output logic         N,
    output logic         V,
    output logic         Z,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CW   = $clog2(M + 1);
    localparam logic [M:0]  MExt = (M + 1)'(M);

    shift_state_t  r_state, w_state_next;
    shift_mode_t   r_mode, w_mode_in;
    logic [M-1:0]  r_work, w_step_data;
    logic          w_step_bit;
    logic [CW-1:0] r_k, w_k_load;
    logic          r_v, r_c_clr;
    logic          w_b_ge_m, w_b_gt_m, w_v_load, w_c_clr_load;

    assign w_mode_in = shift_mode_t'(mode);

    shift_step #(
        .M (M)
    ) u_step (
        .i_data (r_work),
        .i_mode (r_mode),
        .o_data (w_step_data),
        .o_bit  (w_step_bit)
    );

    // Step count and flag setup derived from the request operands.
    always_comb begin
        w_b_ge_m     = {1'b0, B} >= MExt;
        w_b_gt_m     = {1'b0, B} > MExt;
        w_k_load     = '0;
        w_v_load     = 1'b0;
        w_c_clr_load = 1'b0;
        if (w_mode_in == SH_ROR) begin
            w_k_load = CW'(B % M);
        end else begin
            w_k_load = w_b_ge_m ? CW'(M) : CW'(B);
            w_v_load = w_b_ge_m;
            // Past M steps a logical shift only ejects zeros; ASR keeps ejecting the sign.
            w_c_clr_load = w_b_gt_m && (w_mode_in != SH_ASR);
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != S_IDLE);
        done         = (r_state == S_DONE);
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (w_k_load == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_k == CW'(1)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_work  <= '0;
            r_mode  <= SH_LSL;
            r_k     <= '0;
            r_v     <= 1'b0;
            r_c_clr <= 1'b0;
            R       <= '0;
            C       <= 1'b0;
            N       <= 1'b0;
            V       <= 1'b0;
            Z       <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_work  <= A;
                        r_mode  <= w_mode_in;
                        r_k     <= w_k_load;
                        r_v     <= w_v_load;
                        r_c_clr <= w_c_clr_load;
                        // Zero-step operations publish straight away.
                        if (w_k_load == '0) begin
                            R <= A;
                            C <= 1'b0;
                            N <= A[M-1];
                            V <= w_v_load;
                            Z <= (A == '0);
                        end
                    end
                end
                S_SHIFT: begin
                    r_work <= w_step_data;
                    r_k    <= r_k - CW'(1);
                    if (r_k == CW'(1)) begin
                        R <= w_step_data;
                        C <= r_c_clr ? 1'b0 : w_step_bit;
                        N <= w_step_data[M-1];
                        V <= r_v;
                        Z <= (w_step_data == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shifter_seq.sv
module tb_shifter_seq;
    import shifter_pkg::*;

    typedef struct {
        shift_mode_t mode;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [3:0]  r;
        logic        c;
        logic        n;
        logic        v;
        logic        z;
        int          lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] A = '0;
    logic [3:0] B = '0;
    logic [1:0] mode = '0;
    logic [3:0] R;
    logic       C, N, V, Z, busy, done;

    shift_mode_t st_m;
    logic [3:0]  st_d, st_o;
    logic        st_b;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t sb_q[$];
    logic [3:0] hold_r = '0;

    always #5 clk = ~clk;

    shifter_seq #(
        .M (4)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .mode  (mode),
        .R     (R),
        .C     (C),
        .N     (N),
        .V     (V),
        .Z     (Z),
        .busy  (busy),
        .done  (done)
    );

    shift_step #(
        .M (4)
    ) u_step (
        .i_data (st_d),
        .i_mode (st_m),
        .o_data (st_o),
        .o_bit  (st_b)
    );

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic vec_t mk(shift_mode_t m, logic [3:0] a, logic [3:0] b, logic [3:0] r,
                                logic c, logic n, logic v, logic z, int lat);
        vec_t t;
        t.mode = m; t.a = a; t.b = b; t.r = r;
        t.c = c; t.n = n; t.v = v; t.z = z; t.lat = lat;
        return t;
    endfunction

    // Called just after an edge; lat0 = number of edges since (and including) the start edge.
    task automatic finish_op(input int lat0);
        int   lat;
        int   busy_n;
        logic hold_bad;
        vec_t e;
        lat = lat0;
        busy_n = lat0 - 1;
        hold_bad = 1'b0;
        while (!done && lat < 40) begin
            if (busy) busy_n++;
            if (R !== hold_r) hold_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (done) begin
                if (busy) busy_n++;
                check("R", 32'(R), 32'(e.r));
                check("C", 32'(C), 32'(e.c));
                check("N", 32'(N), 32'(e.n));
                check("V", 32'(V), 32'(e.v));
                check("Z", 32'(Z), 32'(e.z));
                check("latency", 32'(lat), 32'(e.lat));
                check("busy_cycles", 32'(busy_n), 32'(e.lat));
                check("hold_R", 32'(hold_bad), 32'd0);
                hold_r = e.r;
            end
        end
        @(posedge clk); #1;
        check("done_pulse", 32'(done), 32'd0);
        check("idle_after", 32'(busy), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        A = v.a; B = v.b; mode = v.mode; start = 1'b1;
        sb_q.push_back(v);
        @(posedge clk); #1;
        start = 1'b0;
        finish_op(1);
    endtask

    vec_t vecs[15];
    vec_t v9;
    vec_t vh;
    logic saw_done;

    initial begin
        vecs[0]  = mk(SH_LSR, 4'b1011, 4'd2,  4'b0010, 1, 0, 0, 0, 3);
        vecs[1]  = mk(SH_ASR, 4'b1011, 4'd1,  4'b1101, 1, 1, 0, 0, 2);
        vecs[2]  = mk(SH_ASR, 4'b1000, 4'd6,  4'b1111, 1, 1, 1, 0, 5);
        vecs[3]  = mk(SH_LSL, 4'b0011, 4'd5,  4'b0000, 0, 0, 1, 1, 5);
        vecs[4]  = mk(SH_ROR, 4'b0001, 4'd5,  4'b1000, 1, 1, 0, 0, 2);
        vecs[5]  = mk(SH_ROR, 4'b0110, 4'd4,  4'b0110, 0, 0, 0, 0, 1);
        vecs[6]  = mk(SH_LSL, 4'b1010, 4'd0,  4'b1010, 0, 1, 0, 0, 1);
        vecs[7]  = mk(SH_ASR, 4'b1010, 4'd0,  4'b1010, 0, 1, 0, 0, 1);
        vecs[8]  = mk(SH_LSL, 4'b0101, 4'd3,  4'b1000, 0, 1, 0, 0, 4);
        vecs[9]  = mk(SH_LSL, 4'b0111, 4'd4,  4'b0000, 1, 0, 1, 1, 5);
        vecs[10] = mk(SH_LSR, 4'b1000, 4'd4,  4'b0000, 1, 0, 1, 1, 5);
        vecs[11] = mk(SH_LSR, 4'b1111, 4'd9,  4'b0000, 0, 0, 1, 1, 5);
        vecs[12] = mk(SH_ROR, 4'b1001, 4'd3,  4'b0011, 0, 0, 0, 0, 4);
        vecs[13] = mk(SH_ASR, 4'b0110, 4'd15, 4'b0000, 0, 0, 1, 1, 5);
        vecs[14] = mk(SH_ROR, 4'b0110, 4'd15, 4'b1100, 1, 1, 0, 0, 4);

        // Standalone single-step checks.
        st_d = 4'b1010; st_m = SH_LSL; #1;
        check("step_lsl", 32'({st_o, st_b}), 32'b0100_1);
        st_d = 4'b1010; st_m = SH_ASR; #1;
        check("step_asr", 32'({st_o, st_b}), 32'b1101_0);
        st_d = 4'b0101; st_m = SH_LSR; #1;
        check("step_lsr", 32'({st_o, st_b}), 32'b0010_1);
        st_d = 4'b0101; st_m = SH_ROR; #1;
        check("step_ror", 32'({st_o, st_b}), 32'b1010_1);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_R", 32'(R), 32'd0);
        check("rst_flags", 32'({C, N, V, Z}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i]);
        end

        // start while busy is ignored.
        v9 = mk(SH_LSL, 4'b0101, 4'd3, 4'b1000, 0, 1, 0, 0, 4);
        @(negedge clk);
        A = v9.a; B = v9.b; mode = v9.mode; start = 1'b1;
        sb_q.push_back(v9);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        A = 4'b1111; B = 4'd1; mode = 2'b01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_during_ignore", 32'(busy), 32'd1);
        finish_op(2);
        repeat (3) begin
            @(posedge clk); #1;
            check("no_relaunch", 32'(busy), 32'd0);
        end

        // Reset mid-operation aborts without a done pulse.
        @(negedge clk);
        A = 4'b0101; B = 4'd3; mode = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("abort_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_R", 32'(R), 32'd0);
        check("abort_flags", 32'({C, N, V, Z}), 32'd0);
        check("abort_busy_low", 32'(busy), 32'd0);
        check("abort_done_low", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        hold_r = 4'b0000;
        run_vec(v9);

        // start held high relaunches in the first IDLE cycle after DONE.
        vh = mk(SH_LSL, 4'b0011, 4'd1, 4'b0110, 0, 0, 0, 0, 2);
        @(negedge clk);
        A = vh.a; B = vh.b; mode = vh.mode; start = 1'b1;
        sb_q.push_back(vh);
        sb_q.push_back(vh);
        @(posedge clk); #1;
        finish_op(1);
        @(posedge clk); #1;
        check("held_relaunch", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        finish_op(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/shifter_seq.md
Name: shifter_seq

Overview:
Iterative multi-mode shifter, the sequential successor of the combinational right shifter in the ALU lab blocks. It adds four shift modes, a start/done handshake and registered ALU flags (C, N, V, Z). It moves one bit position per clock, trading latency for area. It sits beside the ALU datapath, and a controller FSM drives it.

Parameters:
M, 4, operand and result width in bits (M >= 2)
CW, $clog2(M+1), internal step-counter width (derived; not overridden)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  request; sampled only in IDLE
A  in  M  shiftee
B  in  M  shift amount (unsigned)
mode  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
R  out  M  result, registered
C  out  1  carry: last bit shifted out
N  out  1  R[M-1]
V  out  1  amount out of range
Z  out  1  R == 0
busy  out  1  high in SHIFT and DONE
done  out  1  one-cycle pulse, result and flags valid

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: R=0, C=N=V=Z=0, busy=0, done=0, state=IDLE. Reset wins over every other event, including mid-operation; an aborted operation produces no done pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE with start=1 at an edge:
  - Latch A, mode and B into working registers.
  - Load the step counter k. For LSL/LSR/ASR, k = min(B, M). For ROR, k = B mod M.
  - Next state is SHIFT if k > 0, otherwise DONE.
- SHIFT: each edge applies one single-bit step to the working register, captures the bit shifted out, and decrements k. When k==1 at the edge, the next state is DONE.
- Single-bit steps:
  - LSL shifts in 0 and ejects bit M-1.
  - LSR shifts in 0 and ejects bit 0.
  - ASR shifts in bit M-1 and ejects bit 0.
  - ROR moves bit 0 into bit M-1 and ejects bit 0.
- DONE: for one cycle, done=1 and busy=1. R and the flags update on the edge entering DONE. Next state is IDLE.
- Latency: done is high k+1 cycles after the start edge (k=0 gives 1 cycle). Worst case is M+1 cycles.
- Output hold: R and flags keep their values until the next operation's DONE or reset. They do not change during a later SHIFT.
- start rules: start is ignored while busy=1. If start is held continuously, a new operation launches in the first IDLE cycle after DONE.
- Flag C:
  - Equals the last ejected bit.
  - C=0 when k=0.
  - When B > M: LSL/LSR give C=0, and ASR gives C=A[M-1] (the latched value).
  - ROR with k>0 gives C=R[M-1].
- Flag V: set to 1 when B >= M for LSL/LSR/ASR. V=0 for ROR.
- Flags N and Z: computed from the final R.
- Boundary results:
  - B >= M with LSL/LSR gives R=0.
  - B >= M with ASR gives R equal to M copies of the sign bit.
  - ROR with B mod M == 0 gives R=A and C=0.
- Width rules: everything is unsigned except the ASR fill. No arithmetic width growth. The counter never underflows.

Decomposition:
- Package shifter_pkg holds:
  - typedef enum logic [1:0] shift_mode_t {SH_LSL, SH_LSR, SH_ASR, SH_ROR}
  - typedef enum logic [1:0] shift_state_t {S_IDLE, S_SHIFT, S_DONE}
- One sub-module, shift_step: a combinational single-bit step parametrised by M.
  - Inputs: data and mode.
  - Outputs: next data and the ejected bit.
  - shifter_seq instantiates it once, and the bench can test it standalone.

Test Plan:
- M=4, LSR, A=1011, B=2, start pulse: R=0010, C=1, N=0, Z=0, V=0; done high 3 cycles after the start edge; busy high for 3 cycles.
- M=4, ASR, A=1011, B=1: R=1101, C=1, N=1, V=0, done after 2 cycles. Then ASR A=1000, B=6: R=1111, C=1, V=1, done after 5 cycles.
- M=4, LSL, A=0011, B=5: R=0000, C=0, Z=1, V=1, done after 5 cycles (k capped to 4).
- M=4, ROR: A=0001, B=5 gives k=1, R=1000, C=1, N=1, V=0. Then ROR A=0110, B=4 gives R=0110, C=0, done after 1 cycle.
- M=4, any mode, B=0, A=1010: R=1010, C=0, N=1, V=0, done exactly 1 cycle after start.
- M=4, LSL A=0101 B=3: assert start again while busy → ignored. Then restart, and assert rst 1 cycle after start → next edge gives R=0, all flags 0, busy=0, and no done pulse. Restart after reset → normal result 1000, C=0.
